// File: rtl/dl_mem_arbiter.sv
// dl_mem_arbiter: shares one byte-wide memory port between ROM download
// writes (strict priority, one-entry holding buffer) and core reads.
//
// Optional feature macro: DL_CHECKSUM_EN (builds the dl_sum accumulator).
//
// Ports:
//   clk, reset          core clock, async active-high reset
//   dl_active           download in progress
//   dl_wr/addr/data     one-clock download byte write strobe + payload
//   core_req/addr       level-held read request
//   core_ack/q          one-clock read-complete pulse, read data (held)
//   core_hold           registered dl_active, halts the core
//   mem_addr/din/we/oe  memory controller pins
//   mem_dout            memory read data, valid RD_LAT clocks after oe rise
//   dl_overrun          sticky: a download byte was dropped
//   dl_sum              running download checksum (0 when disabled)
module dl_mem_arbiter #(
    parameter int AW     = 25,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_data,
    input  logic          core_req,
    input  logic [AW-1:0] core_addr,
    output logic          core_ack,
    output logic [7:0]    core_q,
    output logic          core_hold,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    output logic          mem_we,
    output logic          mem_oe,
    input  logic [7:0]    mem_dout,
    output logic          dl_overrun,
    output logic [7:0]    dl_sum
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    localparam logic [3:0] LAT_LAST = 4'(RD_LAT - 1);

    logic [1:0]    state;
    logic          pend;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_data;
    logic [3:0]    lat_cnt;

    logic dl_rise;
    logic take_direct;
    logic consume;
    logic buf_load;
    logic buf_drop;

    assign dl_rise = dl_active & ~core_hold;

    // A byte is buffered whenever it is not written straight from IDLE.
    // The buffer is free if empty, or if IDLE is draining it this edge.
    always_comb begin
        take_direct = (state == S_IDLE) && !pend && dl_wr;
        consume     = (state == S_IDLE) && pend;
        buf_load    = dl_wr && !take_direct && (!pend || consume);
        buf_drop    = dl_wr && pend && !consume;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            pend       <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= 8'h00;
            lat_cnt    <= 4'd0;
            core_ack   <= 1'b0;
            core_q     <= 8'h00;
            core_hold  <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= 8'h00;
            mem_we     <= 1'b0;
            mem_oe     <= 1'b0;
            dl_overrun <= 1'b0;
        end else begin
            core_hold <= dl_active;
            core_ack  <= 1'b0;
            mem_we    <= 1'b0;

            if (buf_load) begin
                buf_addr <= dl_addr;
                buf_data <= dl_data;
            end
            pend <= buf_load | (pend & ~consume);

            // a drop on the rise edge itself still flags
            if (dl_rise) dl_overrun <= 1'b0;
            if (buf_drop) dl_overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (pend) begin
                        state    <= S_WRITE;
                        mem_addr <= buf_addr;
                        mem_din  <= buf_data;
                        mem_we   <= 1'b1;
                    end else if (dl_wr) begin
                        state    <= S_WRITE;
                        mem_addr <= dl_addr;
                        mem_din  <= dl_data;
                        mem_we   <= 1'b1;
                    end else if (core_req && !core_hold) begin
                        state    <= S_READ;
                        mem_addr <= core_addr;
                        mem_oe   <= 1'b1;
                        lat_cnt  <= 4'd0;
                    end
                end
                S_WRITE: begin
                    state <= S_IDLE;
                end
                S_READ: begin
                    if (lat_cnt == LAT_LAST) begin
                        core_q   <= mem_dout;
                        mem_oe   <= 1'b0;
                        core_ack <= 1'b1;
                        state    <= S_ACK;
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DL_CHECKSUM_EN
    logic [7:0] sum_q;

    // mem_din holds the byte being written throughout the WRITE cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= (dl_rise ? 8'h00 : sum_q)
                   + ((state == S_WRITE) ? mem_din : 8'h00);
        end
    end

    assign dl_sum = sum_q;
`else
    assign dl_sum = 8'h00;
`endif

endmodule

// File: tb/tb_dl_mem_arbiter.sv
// tb_dl_mem_arbiter: vector table, directed corner sequences and a
// randomized scoreboard run against dl_mem_arbiter.
module tb_dl_mem_arbiter;

    localparam int AW     = 25;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          dl_active;
    logic          dl_wr;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_data;
    logic          core_req;
    logic [AW-1:0] core_addr;
    logic          core_ack;
    logic [7:0]    core_q;
    logic          core_hold;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_we;
    logic          mem_oe;
    logic [7:0]    mem_dout;
    logic          dl_overrun;
    logic [7:0]    dl_sum;

    always #5 clk = ~clk;

    dl_mem_arbiter #(.AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .dl_active  (dl_active),
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .core_req   (core_req),
        .core_addr  (core_addr),
        .core_ack   (core_ack),
        .core_q     (core_q),
        .core_hold  (core_hold),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_we     (mem_we),
        .mem_oe     (mem_oe),
        .mem_dout   (mem_dout),
        .dl_overrun (dl_overrun),
        .dl_sum     (dl_sum)
    );

    // Read-only memory model: data valid only RD_LAT clocks after oe rise.
    function automatic logic [7:0] mem_model(input logic [AW-1:0] a);
        if (a[11:0] == 12'h123) return 8'h3C;
        return a[7:0] ^ 8'h5A;
    endfunction

    int oe_cnt = 0;
    always @(posedge clk) oe_cnt <= mem_oe ? oe_cnt + 1 : 0;

    assign mem_dout = (mem_oe && oe_cnt >= RD_LAT - 1)
                    ? mem_model(mem_addr) : 8'hEE;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"}, {core_ack, core_q, core_hold, mem_we, mem_oe,
                           dl_overrun, dl_sum, mem_din}, 32'h0);
        chk({nm, "_addr"}, mem_addr, 32'h0);
    endtask

    task automatic do_write(input string nm, input logic [AW-1:0] a,
                            input logic [7:0] d, input logic [7:0] exp);
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        tick();
        dl_wr = 1'b0;
        chk({nm, "_we"}, mem_we, 1);
        chk({nm, "_addr"}, mem_addr, a);
        chk({nm, "_din"}, mem_din, exp);
        tick();
        chk({nm, "_we_end"}, mem_we, 0);
    endtask

    task automatic do_read(input string nm, input logic [AW-1:0] a,
                           input logic [7:0] exp);
        int k;
        core_req  = 1'b1;
        core_addr = a;
        tick();
        chk({nm, "_oe"}, mem_oe, 1);
        chk({nm, "_addr"}, mem_addr, a);
        k = 0;
        while (!core_ack && k < 20) begin
            tick();
            k++;
            if (!core_ack) chk({nm, "_oe_hold"}, mem_oe, 1);
        end
        chk({nm, "_lat"}, k, RD_LAT);
        chk({nm, "_ack"}, core_ack, 1);
        chk({nm, "_q"}, core_q, exp);
        chk({nm, "_oe_off"}, mem_oe, 0);
        core_req = 1'b0;
        tick();
        chk({nm, "_ack_once"}, core_ack, 0);
        tick();
        chk({nm, "_no_reread"}, mem_oe, 0);
    endtask

    typedef struct {
        bit            is_rd;
        logic [AW-1:0] addr;
        logic [7:0]    din;
        logic [7:0]    exp;
    } vec_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    vec_t vt [7];
    wr_t  wq [$];
    wr_t  w;

    logic [7:0] exp_sum;
    logic [7:0] cs_bytes [3];
    logic [AW-1:0] ra;
    bit   outst;
    bit   ack_now;
    bit   bad;
    int   gap;
    int   nxt_gap;
    int   oe_seen;
    int   wait_c;
    int   n_rd;
    int   n_wr;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b0, 25'h0000010, 8'hA5, 8'hA5};
        vt[1] = '{1'b1, 25'h0000123, 8'h00, 8'h3C};
        vt[2] = '{1'b0, 25'h1FFFFFF, 8'h00, 8'h00};
        vt[3] = '{1'b1, 25'h1000123, 8'h00, 8'h3C};
        vt[4] = '{1'b1, 25'h0000007, 8'h00, 8'h5D};
        vt[5] = '{1'b0, 25'h0ABCDEF, 8'h7E, 8'h7E};
        vt[6] = '{1'b1, 25'h00000FF, 8'h00, 8'hA5};

        reset     = 1'b1;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        dl_addr   = '0;
        dl_data   = 8'h00;
        core_req  = 1'b0;
        core_addr = '0;

        tick();
        tick();
        chk_zero("reset");
        reset = 1'b0;
        tick();
        chk_zero("post_reset");

        for (int i = 0; i < 7; i++) begin
            if (vt[i].is_rd)
                do_read($sformatf("vec%0d_rd", i), vt[i].addr, vt[i].exp);
            else
                do_write($sformatf("vec%0d_wr", i), vt[i].addr,
                         vt[i].din, vt[i].exp);
        end

        // write arriving one clock into a read waits in the buffer
        core_req  = 1'b1;
        core_addr = 25'h0123;
        tick();
        dl_wr   = 1'b1;
        dl_addr = 25'h200;
        dl_data = 8'h55;
        tick();
        dl_wr = 1'b0;
        chk("wdr_oe", mem_oe, 1);
        chk("wdr_no_we", mem_we, 0);
        tick();
        chk("wdr_ack", core_ack, 1);
        chk("wdr_q", core_q, 8'h3C);
        core_req = 1'b0;
        tick();
        chk("wdr_ack_end", {core_ack, mem_we}, 2'b00);
        tick();
        chk("wdr_we", mem_we, 1);
        chk("wdr_addr", mem_addr, 25'h200);
        chk("wdr_din", mem_din, 8'h55);
        chk("wdr_ovr", dl_overrun, 0);
        tick();
        chk("wdr_we_end", mem_we, 0);

        // buffer drained and refilled on the same edge: no overrun
        dl_wr   = 1'b1;
        dl_addr = 25'h210;
        dl_data = 8'hB1;
        tick();
        chk("fill_b1", {mem_we, mem_din}, {1'b1, 8'hB1});
        dl_addr = 25'h211;
        dl_data = 8'hB2;
        tick();
        chk("fill_gap", mem_we, 0);
        dl_addr = 25'h212;
        dl_data = 8'hB3;
        tick();
        dl_wr = 1'b0;
        chk("fill_b2", {mem_we, mem_din}, {1'b1, 8'hB2});
        chk("fill_b2_addr", mem_addr, 25'h211);
        tick();
        chk("fill_gap2", mem_we, 0);
        tick();
        chk("fill_b3", {mem_we, mem_din}, {1'b1, 8'hB3});
        chk("fill_b3_addr", mem_addr, 25'h212);
        chk("fill_ovr", dl_overrun, 0);
        tick();
        chk("fill_end", mem_we, 0);

        // three back-to-back bytes during a read: only the first survives
        core_req  = 1'b1;
        core_addr = 25'h0123;
        tick();
        dl_wr   = 1'b1;
        dl_addr = 25'h300;
        dl_data = 8'h01;
        tick();
        chk("ovr_oe", mem_oe, 1);
        chk("ovr_flag0", dl_overrun, 0);
        dl_data = 8'h02;
        tick();
        chk("ovr_ack", {core_ack, core_q}, {1'b1, 8'h3C});
        chk("ovr_flag1", dl_overrun, 1);
        core_req = 1'b0;
        dl_data  = 8'h03;
        tick();
        dl_wr = 1'b0;
        chk("ovr_idle", {core_ack, mem_we}, 2'b00);
        tick();
        chk("ovr_we", {mem_we, mem_din}, {1'b1, 8'h01});
        chk("ovr_addr", mem_addr, 25'h300);
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_we) bad = 1'b1;
        end
        chk("ovr_dropped", bad, 0);
        chk("ovr_sticky", dl_overrun, 1);

        // download start: hold the core, clear the sticky flag and sum
        dl_active = 1'b1;
        tick();
        chk("hold_set", core_hold, 1);
        chk("hold_ovr_clr", dl_overrun, 0);
        chk("hold_sum_clr", dl_sum, 8'h00);
        core_req  = 1'b1;
        core_addr = 25'h0123;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_oe || core_ack) bad = 1'b1;
        end
        chk("hold_no_read", bad, 0);

        cs_bytes[0] = 8'hFF;
        cs_bytes[1] = 8'h02;
        cs_bytes[2] = 8'h10;
        for (int i = 0; i < 3; i++) begin
            dl_wr   = 1'b1;
            dl_addr = 25'h500 + AW'(i);
            dl_data = cs_bytes[i];
            tick();
            dl_wr = 1'b0;
            chk($sformatf("cs_we%0d", i), {mem_we, mem_din},
                {1'b1, cs_bytes[i]});
            tick();
        end
`ifdef DL_CHECKSUM_EN
        exp_sum = 8'h11;
`else
        exp_sum = 8'h00;
`endif
        chk("cs_sum", dl_sum, exp_sum);
        chk("cs_ovr", dl_overrun, 0);

        // drop download, let the pending read start, reset mid-read
        dl_active = 1'b0;
        tick();
        chk("hold_clr", core_hold, 0);
        chk("hold_lag", mem_oe, 0);
        tick();
        chk("rst_rd_start", mem_oe, 1);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("rst_async");
        core_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (core_ack || mem_oe || mem_we) bad = 1'b1;
        end
        chk("rst_no_ack", bad, 0);
        chk_zero("rst_after");

        // randomized traffic, download bytes at safe spacing
        outst   = 1'b0;
        gap     = 100;
        nxt_gap = RD_LAT + 2;
        oe_seen = 0;
        wait_c  = 0;
        n_rd    = 0;
        n_wr    = 0;
        ra      = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            ack_now = core_ack;
            if (mem_we) begin
                if (wq.size() == 0) begin
                    chk("rnd_we_unexpected", 1, 0);
                end else begin
                    w = wq.pop_front();
                    chk("rnd_we_addr", mem_addr, w.a);
                    chk("rnd_we_din", mem_din, w.d);
                    n_wr++;
                end
                if (mem_oe) chk("rnd_we_oe_both", 1, 0);
            end
            if (outst) begin
                wait_c++;
                if (mem_oe) begin
                    oe_seen++;
                    chk("rnd_rd_addr", mem_addr, ra);
                end
                if (core_ack) begin
                    chk("rnd_rd_q", core_q, ra[7:0] ^ 8'h5A);
                    chk("rnd_rd_oe_len", oe_seen, RD_LAT);
                    outst    = 1'b0;
                    core_req = 1'b0;
                    n_rd++;
                end else if (wait_c > 60) begin
                    chk("rnd_rd_timeout", wait_c, 0);
                    outst    = 1'b0;
                    core_req = 1'b0;
                end
            end else if (core_ack) begin
                chk("rnd_spurious_ack", core_ack, 0);
            end

            dl_wr = 1'b0;
            gap++;
            if (cyc < 3800) begin
                if (gap >= nxt_gap && $urandom_range(0, 2) == 0) begin
                    dl_wr   = 1'b1;
                    dl_addr = AW'(25'h400 + $urandom_range(0, 1023));
                    dl_data = 8'($urandom);
                    w.a = dl_addr;
                    w.d = dl_data;
                    wq.push_back(w);
                    gap     = 0;
                    nxt_gap = $urandom_range(RD_LAT + 2, RD_LAT + 6);
                end
                if (!outst && !ack_now && $urandom_range(0, 3) == 0) begin
                    ra        = AW'($urandom_range(0, 255));
                    core_req  = 1'b1;
                    core_addr = ra;
                    outst     = 1'b1;
                    oe_seen   = 0;
                    wait_c    = 0;
                end
            end
        end
        chk("rnd_wq_drained", wq.size(), 0);
        chk("rnd_rd_drained", outst, 0);
        chk("rnd_ovr", dl_overrun, 0);
        chk("rnd_activity", (n_rd > 20) && (n_wr > 20), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dl_mem_arbiter.md
# dl_mem_arbiter

Shares one external byte-wide memory port between the ROM download writer and the emulated core's read requests. Download write pulses (one per byte, already qualified to `clk`) are buffered in a one-entry holding register and get strict priority. Core reads are accepted only outside downloads and are served through a fixed-latency req/ack handshake. The block sits between the download client, the core bus and the memory controller pins.

## Interface
Parameters:
- `AW`, default 25: address width.
- `RD_LAT`, default 2: memory read latency, in clocks from `mem_oe` rising to valid `mem_dout`; legal range 1..15.

Ports:
- `clk` in 1: core clock.
- `reset` in 1: asynchronous, active-high reset.
- `dl_active` in 1: download in progress.
- `dl_wr` in 1: one-clock write strobe.
- `dl_addr` in AW: download byte address.
- `dl_data` in 8: download byte.
- `core_req` in 1: read request, level-held.
- `core_addr` in AW: read address.
- `core_ack` out 1: one-clock read-complete pulse.
- `core_q` out 8: read data, valid while `core_ack`=1 and held until the next read completes.
- `core_hold` out 1: registered copy of `dl_active`; keeps the core halted.
- `mem_addr` out AW: memory address.
- `mem_din` out 8: memory write data.
- `mem_we` out 1: memory write enable.
- `mem_oe` out 1: memory output enable.
- `mem_dout` in 8: memory read data.
- `dl_overrun` out 1: sticky flag, download byte dropped.
- `dl_sum` out 8: running download checksum (see Configuration).

## Operation
- States: IDLE, WRITE, READ, ACK. All outputs are registered.
- Holding buffer: `pend`, `buf_addr`, `buf_data`.
- IDLE, evaluated in priority order:
  - If `pend`=1: go to WRITE with the buffer contents.
  - Else if `dl_wr`=1: go to WRITE with `dl_addr`/`dl_data` directly, bypassing the buffer.
  - Else if `core_req`=1 and `core_hold`=0: go to READ, with `mem_addr`=`core_addr`, `mem_oe`=1, latency counter=0.
  - Else stay in IDLE with `mem_we`=`mem_oe`=0.
- WRITE: `mem_we`=1 for exactly one clock.
  - `pend` clears if the buffer was the source.
  - Next state is IDLE.
- READ: hold `mem_oe`=1 and `mem_addr` for RD_LAT clocks.
  - On the last edge: capture `mem_dout` into `core_q`, drop `mem_oe`, set `core_ack`=1, go to ACK.
- ACK: `core_ack` stays high for this one clock, then IDLE.
  - No new request is accepted in ACK.
  - The requester must drop `core_req` by the edge that ends ACK, or it is treated as a new read.
- Buffering rules for a `dl_wr` that is not taken directly from IDLE:
  - In WRITE, READ or ACK with `pend`=0: latch into the buffer and set `pend`.
  - With `pend`=1, and the buffer not being consumed at that edge: drop the new byte and set `dl_overrun`.
  - With `pend`=1 while IDLE is moving to WRITE with the buffer at that same edge: latch the new byte and keep `pend`=1. This is not an overrun.
- Downloads do not abort a read in progress. The read completes normally and writes wait in the buffer.
- `dl_wr` is honoured regardless of `dl_active`.
- Rising edge of `dl_active` (detected against `core_hold`) clears `dl_overrun` and `dl_sum`.
- Address arithmetic: none. Addresses pass through unmodified.

## Timing
- Reset values: state IDLE, `pend`=0, and all outputs 0, including `core_hold`, `mem_addr`, `mem_din`, `core_q`, `dl_overrun` and `dl_sum`.
- Reset asserted mid-operation: `mem_we`/`mem_oe` drop immediately (asynchronously). A buffered byte or in-flight read is lost and no `core_ack` is issued.
- Write latency, with `dl_wr` sampled at edge E0 while IDLE and `pend`=0: `mem_we` is high from E0 to E1.
- Read latency, with `core_req` sampled at edge E0 in IDLE: `mem_oe` is high from E0 to E0+RD_LAT; `core_ack` is high from E0+RD_LAT to E0+RD_LAT+1.
- Read occupancy: RD_LAT+1 clocks per read.
- Maximum sustained `dl_wr` rate without overrun:
  - One per 2 clocks when no read is in flight.
  - Any gap of at least RD_LAT+2 clocks is safe when a read is in flight.
- `core_hold` lags `dl_active` by one clock.

## Configuration
- `DL_CHECKSUM_EN` defined:
  - `dl_sum` accumulates `mem_din` mod 256 on every WRITE cycle.
  - `dl_sum` is cleared on the `dl_active` rising edge and by reset.
- `DL_CHECKSUM_EN` undefined:
  - No accumulator logic is built; `dl_sum` is constant 8'h00.
  - All other behaviour is identical.

## Test plan
- Single write:
  - Stimulus: `dl_wr` pulse with addr 0x000010, data 0xA5, in IDLE.
  - Required: `mem_we` high for exactly one clock on the next cycle, with `mem_addr`=0x000010 and `mem_din`=0xA5.
- Read, RD_LAT=2:
  - Stimulus: `core_req` with addr 0x0123; the memory model returns 0x3C.
  - Required: `mem_oe` high for 2 clocks; `core_ack` pulses for one clock at the 2nd edge with `core_q`=0x3C; exactly one ack per request.
- Write during read:
  - Stimulus: `dl_wr` (0x55) one clock after a read starts.
  - Required: read completes unchanged; the write is issued from the buffer in the IDLE cycle after ACK; `dl_overrun` stays 0.
- Overrun:
  - Stimulus: three `dl_wr` pulses on consecutive clocks (data 0x01, 0x02, 0x03) during a read.
  - Required: 0x01 is written; 0x02 and 0x03 are dropped; `dl_overrun`=1 until the next `dl_active` rise.
- Hold and reset:
  - Stimulus: `dl_active`=1 with `core_req`=1.
  - Required: no read is issued and `core_hold`=1 after one clock.
  - Stimulus: assert `reset` mid-read.
  - Required: `mem_oe`=0 immediately, no `core_ack`, all outputs 0.
- Checksum, with `DL_CHECKSUM_EN`:
  - Stimulus: download bytes 0xFF, 0x02, 0x10.
  - Required: `dl_sum`=0x11.
  - Without the macro, `dl_sum`=0x00 throughout.
